// File: rtl/atmos_light_ctrl.sv
// atmos_light_ctrl: per-frame atmospheric light (A) estimator for the dehaze stage.
// Tracks the dark-channel maximum over each active frame and checks the pixel
// and line counts. During vertical blanking it runs a shift-based IIR update
// with a clamp, so A only ever changes between frames.
module atmos_light_ctrl #(
  parameter int H_DISP      = 1280,
  parameter int V_DISP      = 720,
  parameter int ALPHA_SHIFT = 2,
  parameter int A_MIN       = 64,
  parameter int A_DEFAULT   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Dark,
  input  logic       cfg_freeze,
  output logic [7:0] atmospheric_light,
  output logic       atmos_update,
  output logic       atmos_locked,
  output logic       frame_err
);

  localparam logic [21:0] PIX_TARGET  = 22'(H_DISP * V_DISP);
  localparam logic [11:0] LINE_TARGET = 12'(V_DISP);
  localparam logic [7:0]  A_MIN_V     = 8'(A_MIN);
  localparam logic [7:0]  A_DEFAULT_V = 8'(A_DEFAULT);

  typedef enum logic [2:0] {IDLE, ACCUM, CHECK, FILTER, UPDATE} state_t;

  state_t      state;
  logic        vsync_d;
  logic        href_d;
  logic [21:0] pix_cnt;
  logic [11:0] line_cnt;
  logic [7:0]  dark_max;
  logic [7:0]  target_a;
  logic        start_pending;

  logic        vs_rise;
  logic        vs_fall;
  logic        href_fall;
  logic        pix_valid;
  logic        restart;
  logic        frame_good;

  logic signed [9:0] diff;
  logic signed [9:0] step;
  logic signed [9:0] sum;
  logic [7:0]        filt_a;

  // Registered copies of the sync inputs for edge detection. vsync_d comes out
  // of reset high so a frame already in progress at reset never looks like a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b1;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
    end
  end

  // Edge strobes, pixel qualifier and the frame-complete test
  always_comb begin
    vs_rise    = per_frame_vsync & ~vsync_d;
    vs_fall    = ~per_frame_vsync & vsync_d;
    href_fall  = ~per_frame_href & href_d;
    pix_valid  = per_frame_clken & per_frame_href & per_frame_vsync;
    restart    = start_pending | vs_rise;
    frame_good = (pix_cnt == PIX_TARGET) && (line_cnt == LINE_TARGET);
  end

  // IIR step toward the frame maximum, then clamp into [A_MIN, 255].
  // The arithmetic shift floors, so small positive differences are dropped.
  always_comb begin
    diff = $signed({2'b00, dark_max}) - $signed({2'b00, atmospheric_light});
    step = diff >>> ALPHA_SHIFT;
    if (atmos_locked) begin
      sum = $signed({2'b00, atmospheric_light}) + step;
    end else begin
      sum = $signed({2'b00, dark_max});
    end
    if (sum < $signed({2'b00, A_MIN_V})) begin
      filt_a = A_MIN_V;
    end else if (sum > 10'sd255) begin
      filt_a = 8'd255;
    end else begin
      filt_a = sum[7:0];
    end
  end

  // Frame sequencer: IDLE -> ACCUM -> CHECK -> FILTER -> UPDATE, with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      pix_cnt           <= '0;
      line_cnt          <= '0;
      dark_max          <= '0;
      target_a          <= '0;
      start_pending     <= 1'b0;
      atmospheric_light <= A_DEFAULT_V;
      atmos_update      <= 1'b0;
      atmos_locked      <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      atmos_update <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_rise) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            dark_max <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (pix_valid) begin
            if (pix_cnt != {22{1'b1}}) pix_cnt <= pix_cnt + 22'd1;
            if (per_img_Dark > dark_max) dark_max <= per_img_Dark;
          end
          if (href_fall && (line_cnt != {12{1'b1}})) line_cnt <= line_cnt + 12'd1;
          if (vs_fall) state <= CHECK;
        end
        CHECK: begin
          if (frame_good) begin
            if (vs_rise) start_pending <= 1'b1;
            state <= FILTER;
          end else begin
            frame_err <= 1'b1;
            if (restart) begin
              pix_cnt       <= '0;
              line_cnt      <= '0;
              dark_max      <= '0;
              start_pending <= 1'b0;
              state         <= ACCUM;
            end else begin
              state <= IDLE;
            end
          end
        end
        FILTER: begin
          if (vs_rise) start_pending <= 1'b1;
          target_a <= filt_a;
          state    <= UPDATE;
        end
        UPDATE: begin
          if (!cfg_freeze) begin
            atmospheric_light <= target_a;
            atmos_update      <= 1'b1;
            atmos_locked      <= 1'b1;
          end
          if (restart) begin
            pix_cnt       <= '0;
            line_cnt      <= '0;
            dark_max      <= '0;
            start_pending <= 1'b0;
            state         <= ACCUM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atmos_light_ctrl.sv
// Directed bench for atmos_light_ctrl on a 4x2 frame. Two instances share all
// inputs: u_dut uses ALPHA_SHIFT=2, u_dut0 uses ALPHA_SHIFT=0 (direct load).
module tb_atmos_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       href;
  logic       clken;
  logic [7:0] dark;
  logic       freeze;

  logic [7:0] a_light;
  logic       a_upd;
  logic       a_lock;
  logic       f_err;
  logic [7:0] a0_light;
  logic       a0_upd;
  logic       a0_lock;
  logic       f0_err;

  int checks = 0;
  int failures = 0;
  int upd_total = 0;
  int err_total = 0;
  int upd0_total = 0;
  int err0_total = 0;

  int r_upd_cnt;
  int r_upd_edge;
  int r_err_cnt;
  int r_err_edge;
  int r_chg_edge;

  logic [7:0] frame_px [0:11];

  atmos_light_ctrl #(
    .H_DISP(4), .V_DISP(2), .ALPHA_SHIFT(2), .A_MIN(64), .A_DEFAULT(255)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Dark(dark), .cfg_freeze(freeze),
    .atmospheric_light(a_light), .atmos_update(a_upd),
    .atmos_locked(a_lock), .frame_err(f_err)
  );

  atmos_light_ctrl #(
    .H_DISP(4), .V_DISP(2), .ALPHA_SHIFT(0), .A_MIN(64), .A_DEFAULT(255)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
    .per_img_Dark(dark), .cfg_freeze(freeze),
    .atmospheric_light(a0_light), .atmos_update(a0_upd),
    .atmos_locked(a0_lock), .frame_err(f0_err)
  );

  always #5 clk = ~clk;

  // Pulse totals sampled on the falling edge
  always @(negedge clk) begin
    if (a_upd === 1'b1) upd_total++;
    if (f_err === 1'b1) err_total++;
    if (a0_upd === 1'b1) upd0_total++;
    if (f0_err === 1'b1) err0_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7);
    frame_px[0] = p0; frame_px[1] = p1; frame_px[2] = p2; frame_px[3] = p3;
    frame_px[4] = p4; frame_px[5] = p5; frame_px[6] = p6; frame_px[7] = p7;
    for (int i = 8; i < 12; i++) frame_px[i] = 8'd0;
  endtask

  // Drives one frame of n_lines href pulses (4 cycles each) carrying up to
  // total_pix valid pixels; ends on the tick whose edge samples the vsync fall.
  task automatic send_frame(input bit do_rise, input int total_pix, input int n_lines);
    int idx;
    if (do_rise) begin
      vsync = 1'b1;
      tick();
    end
    tick();
    for (int l = 0; l < n_lines; l++) begin
      href = 1'b1;
      for (int p = 0; p < 4; p++) begin
        idx = l * 4 + p;
        if (idx < total_pix) begin
          clken = 1'b1;
          dark  = frame_px[idx];
        end else begin
          clken = 1'b0;
          dark  = 8'd0;
        end
        tick();
      end
      href  = 1'b0;
      clken = 1'b0;
      dark  = 8'd0;
      tick();
      tick();
    end
    vsync = 1'b0;
    tick();
  endtask

  // Observes six edges after the vsync-fall edge and records pulse counts and
  // the edge index of the first pulse / first change of A.
  task automatic wait_result(input string name);
    logic [7:0] a_prev;
    a_prev     = a_light;
    r_upd_cnt  = 0;
    r_upd_edge = 0;
    r_err_cnt  = 0;
    r_err_edge = 0;
    r_chg_edge = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (a_upd === 1'b1) begin
        r_upd_cnt++;
        if (r_upd_edge == 0) r_upd_edge = k;
      end
      if (f_err === 1'b1) begin
        r_err_cnt++;
        if (r_err_edge == 0) r_err_edge = k;
      end
      if ((a_light !== a_prev) && (r_chg_edge == 0)) r_chg_edge = k;
    end
    $display("frame %s: A=%0d A0=%0d upd=%0d@%0d err=%0d@%0d locked=%0b",
             name, a_light, a0_light, r_upd_cnt, r_upd_edge, r_err_cnt, r_err_edge, a_lock);
  endtask

  task automatic test_reset();
    int bad_a;
    int up0;
    int er0;
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; dark = 8'd0; freeze = 1'b0;
    tick(); tick(); tick();
    checks++; if (a_light !== 8'd255) begin failures++; $display("FAIL reset_a: got %0d expected 255", a_light); end
    checks++; if (a_lock !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0b expected 0", a_lock); end
    checks++; if (a0_light !== 8'd255) begin failures++; $display("FAIL reset_a0: got %0d expected 255", a0_light); end
    rst_n = 1'b1;
    up0 = upd_total;
    er0 = err_total;
    bad_a = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if ((a_light !== 8'd255) || (a_lock !== 1'b0)) bad_a++;
    end
    checks++; if (bad_a != 0) begin failures++; $display("FAIL idle_hold: got %0d bad cycles expected 0", bad_a); end
    checks++; if (upd_total - up0 != 0) begin failures++; $display("FAIL idle_upd: got %0d pulses expected 0", upd_total - up0); end
    checks++; if (err_total - er0 != 0) begin failures++; $display("FAIL idle_err: got %0d pulses expected 0", err_total - er0); end
    $display("reset: A=%0d locked=%0b after 1000 idle cycles", a_light, a_lock);
  endtask

  task automatic test_first_lock();
    set_px(8'd10, 8'd200, 8'd37, 8'd90, 8'd5, 8'd180, 8'd0, 8'd77);
    send_frame(1'b1, 8, 2);
    wait_result("first_lock");
    checks++; if (r_err_cnt != 0) begin failures++; $display("FAIL lock_err: got %0d expected 0", r_err_cnt); end
    checks++; if (r_upd_cnt != 1) begin failures++; $display("FAIL lock_upd_width: got %0d expected 1", r_upd_cnt); end
    checks++; if (r_upd_edge != 3) begin failures++; $display("FAIL lock_upd_edge: got %0d expected 3", r_upd_edge); end
    checks++; if (r_chg_edge != 3) begin failures++; $display("FAIL lock_a_edge: got %0d expected 3", r_chg_edge); end
    checks++; if (a_light !== 8'd200) begin failures++; $display("FAIL lock_a: got %0d expected 200", a_light); end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL lock_flag: got %0b expected 1", a_lock); end
    checks++; if (a0_light !== 8'd200) begin failures++; $display("FAIL lock_a0: got %0d expected 200", a0_light); end
    checks++; if (a0_lock !== 1'b1) begin failures++; $display("FAIL lock_flag0: got %0b expected 1", a0_lock); end
  endtask

  task automatic test_iir();
    set_px(8'd3, 8'd100, 8'd50, 8'd7, 8'd99, 8'd0, 8'd1, 8'd2);
    send_frame(1'b1, 8, 2);
    wait_result("iir_down");
    checks++; if (r_chg_edge != 3) begin failures++; $display("FAIL iir_down_edge: got %0d expected 3", r_chg_edge); end
    checks++; if (a_light !== 8'd175) begin failures++; $display("FAIL iir_down_a: got %0d expected 175", a_light); end
    checks++; if (a0_light !== 8'd100) begin failures++; $display("FAIL iir_down_a0: got %0d expected 100", a0_light); end
    set_px(8'd255, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    send_frame(1'b1, 8, 2);
    wait_result("iir_up");
    checks++; if (a_light !== 8'd195) begin failures++; $display("FAIL iir_up_a: got %0d expected 195", a_light); end
    checks++; if (a0_light !== 8'd255) begin failures++; $display("FAIL iir_up_a0: got %0d expected 255", a0_light); end
  endtask

  task automatic test_clamp();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set_px(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    send_frame(1'b1, 8, 2);
    wait_result("clamp_first");
    checks++; if (a_light !== 8'd64) begin failures++; $display("FAIL clamp_first_a: got %0d expected 64", a_light); end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL clamp_first_lock: got %0b expected 1", a_lock); end
    checks++; if (a0_light !== 8'd64) begin failures++; $display("FAIL clamp_first_a0: got %0d expected 64", a0_light); end
    set_px(8'd70, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    send_frame(1'b1, 8, 2);
    wait_result("clamp_to70");
    checks++; if (a_light !== 8'd65) begin failures++; $display("FAIL small_step_a: got %0d expected 65", a_light); end
    checks++; if (a0_light !== 8'd70) begin failures++; $display("FAIL load70_a0: got %0d expected 70", a0_light); end
    set_px(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    send_frame(1'b1, 8, 2);
    wait_result("clamp_locked");
    checks++; if (a_light !== 8'd64) begin failures++; $display("FAIL clamp_locked_a: got %0d expected 64", a_light); end
    checks++; if (a0_light !== 8'd64) begin failures++; $display("FAIL clamp_locked_a0: got %0d expected 64", a0_light); end
  endtask

  task automatic test_bad_frames();
    set_px(8'd250, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    send_frame(1'b1, 7, 2);
    wait_result("short_pix");
    checks++; if (r_err_cnt != 1) begin failures++; $display("FAIL short_err_cnt: got %0d expected 1", r_err_cnt); end
    checks++; if (r_err_edge != 1) begin failures++; $display("FAIL short_err_edge: got %0d expected 1", r_err_edge); end
    checks++; if (r_upd_cnt != 0) begin failures++; $display("FAIL short_upd: got %0d expected 0", r_upd_cnt); end
    checks++; if (a_light !== 8'd64) begin failures++; $display("FAIL short_a: got %0d expected 64", a_light); end
    checks++; if (a0_light !== 8'd64) begin failures++; $display("FAIL short_a0: got %0d expected 64", a0_light); end
    send_frame(1'b1, 8, 3);
    wait_result("extra_line");
    checks++; if (r_err_cnt != 1) begin failures++; $display("FAIL lines_err_cnt: got %0d expected 1", r_err_cnt); end
    checks++; if (r_upd_cnt != 0) begin failures++; $display("FAIL lines_upd: got %0d expected 0", r_upd_cnt); end
    checks++; if (a_light !== 8'd64) begin failures++; $display("FAIL lines_a: got %0d expected 64", a_light); end
  endtask

  task automatic test_freeze();
    freeze = 1'b1;
    set_px(8'd200, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    send_frame(1'b1, 8, 2);
    wait_result("frozen");
    checks++; if (r_upd_cnt != 0) begin failures++; $display("FAIL freeze_upd: got %0d expected 0", r_upd_cnt); end
    checks++; if (r_err_cnt != 0) begin failures++; $display("FAIL freeze_err: got %0d expected 0", r_err_cnt); end
    checks++; if (a_light !== 8'd64) begin failures++; $display("FAIL freeze_a: got %0d expected 64", a_light); end
    checks++; if (a0_light !== 8'd64) begin failures++; $display("FAIL freeze_a0: got %0d expected 64", a0_light); end
    freeze = 1'b0;
    send_frame(1'b1, 8, 2);
    wait_result("unfrozen");
    checks++; if (a_light !== 8'd98) begin failures++; $display("FAIL unfreeze_a: got %0d expected 98", a_light); end
    checks++; if (a0_light !== 8'd200) begin failures++; $display("FAIL unfreeze_a0: got %0d expected 200", a0_light); end
  endtask

  task automatic test_reset_mid_frame();
    set_px(8'd30, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30, 8'd30);
    vsync = 1'b1;
    tick();
    tick();
    href = 1'b1; clken = 1'b1; dark = 8'd30;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checks++; if (a_light !== 8'd255) begin failures++; $display("FAIL midrst_a: got %0d expected 255", a_light); end
    checks++; if (a_lock !== 1'b0) begin failures++; $display("FAIL midrst_lock: got %0b expected 0", a_lock); end
    checks++; if (a0_light !== 8'd255) begin failures++; $display("FAIL midrst_a0: got %0d expected 255", a0_light); end
    tick();
    rst_n = 1'b1;
    tick();
    href = 1'b1; clken = 1'b1; dark = 8'd30;
    tick(); tick(); tick(); tick();
    href = 1'b0; clken = 1'b0; dark = 8'd0;
    tick(); tick();
    vsync = 1'b0;
    tick();
    wait_result("after_reset");
    checks++; if (r_err_cnt != 0) begin failures++; $display("FAIL midrst_err: got %0d expected 0", r_err_cnt); end
    checks++; if (r_upd_cnt != 0) begin failures++; $display("FAIL midrst_upd: got %0d expected 0", r_upd_cnt); end
    checks++; if (a_light !== 8'd255) begin failures++; $display("FAIL midrst_hold: got %0d expected 255", a_light); end
  endtask

  task automatic test_back_to_back();
    int up0;
    int er0;
    up0 = upd_total;
    er0 = err_total;
    set_px(8'd120, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7);
    send_frame(1'b1, 8, 2);
    vsync = 1'b1;
    tick();
    checks++; if (f_err !== 1'b0) begin failures++; $display("FAIL b2b_first_err: got %0b expected 0", f_err); end
    send_frame(1'b0, 8, 2);
    wait_result("back_to_back");
    checks++; if (r_err_cnt != 1) begin failures++; $display("FAIL b2b_err_cnt: got %0d expected 1", r_err_cnt); end
    checks++; if (r_err_edge != 1) begin failures++; $display("FAIL b2b_err_edge: got %0d expected 1", r_err_edge); end
    checks++; if (upd_total - up0 != 1) begin failures++; $display("FAIL b2b_upd_total: got %0d expected 1", upd_total - up0); end
    checks++; if (err_total - er0 != 1) begin failures++; $display("FAIL b2b_err_total: got %0d expected 1", err_total - er0); end
    checks++; if (a_light !== 8'd120) begin failures++; $display("FAIL b2b_a: got %0d expected 120", a_light); end
    checks++; if (a0_light !== 8'd120) begin failures++; $display("FAIL b2b_a0: got %0d expected 120", a0_light); end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL b2b_lock: got %0b expected 1", a_lock); end
  endtask

  initial begin
    test_reset();
    test_first_lock();
    test_iir();
    test_clamp();
    test_bad_frames();
    test_freeze();
    test_reset_mid_frame();
    test_back_to_back();
    tick();
    checks++; if (upd_total != 8) begin failures++; $display("FAIL total_upd: got %0d expected 8", upd_total); end
    checks++; if (err_total != 3) begin failures++; $display("FAIL total_err: got %0d expected 3", err_total); end
    checks++; if (upd0_total != 8) begin failures++; $display("FAIL total_upd0: got %0d expected 8", upd0_total); end
    checks++; if (err0_total != 3) begin failures++; $display("FAIL total_err0: got %0d expected 3", err0_total); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atmos_light_ctrl.md
Name: atmos_light_ctrl

Overview:
Per-frame controller that estimates and schedules the atmospheric light value A used by the dark-channel dehaze transmission stage. It watches the dark-channel pixel stream and tracks the frame maximum. It checks that the frame arrived complete. In the vertical blanking interval it updates A through a shift-based IIR filter and a clamp, so A stays constant during every active frame. A is clamped to a non-zero minimum because the downstream divider uses A as its divisor.

Parameters:
H_DISP, 1280, expected valid pixels per line
V_DISP, 720, expected lines per frame
ALPHA_SHIFT, 2, IIR smoothing shift, 0..7; 0 = load target directly
A_MIN, 64, lower clamp on A; never 0
A_DEFAULT, 255, A value out of reset

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  high during active frame
per_frame_href  in  1  high during active line
per_frame_clken  in  1  pixel valid strobe
per_img_Dark  in  8  dark-channel pixel
cfg_freeze  in  1  1 = keep current A, skip updates
atmospheric_light  out  8  current A, to transmission stage
atmos_update  out  1  one-cycle pulse when A is written
atmos_locked  out  1  set after first accepted frame
frame_err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset: clk and rst_n as already decided (clock clk; reset rst_n, asynchronous, active-low). On reset:
  - atmospheric_light = A_DEFAULT.
  - atmos_update, atmos_locked, frame_err = 0.
  - State IDLE; all counters and dark_max = 0.
  - Reset mid-frame: the partial frame is lost; the next vsync rise starts clean.
- Edge detection uses registered copies of vsync and href:
  - vs_rise = vsync & ~vsync_d; vs_fall = ~vsync & vsync_d.
  - href_fall = ~href & href_d.
- Valid pixel = clken & href & vsync, sampled only in state ACCUM.
- State IDLE: on vs_rise, clear pix_cnt, line_cnt, dark_max and go to ACCUM. vs_fall in IDLE is ignored, so a frame already in progress at reset is discarded.
- State ACCUM:
  - Each valid pixel: pix_cnt += 1, saturating at 2^22-1; dark_max <= max(dark_max, per_img_Dark).
  - Each href_fall: line_cnt += 1, saturating at 4095.
  - On vs_fall: go to CHECK.
- State CHECK, one cycle:
  - Frame is good if pix_cnt == H_DISP*V_DISP and line_cnt == V_DISP.
  - Good frame: go to FILTER.
  - Bad frame: frame_err = 1 for one cycle, A unchanged, go to IDLE.
- State FILTER, one cycle:
  - If atmos_locked = 0, target_A = dark_max.
  - Otherwise diff = dark_max - A, 9-bit signed, and target_A = A + (diff >>> ALPHA_SHIFT), arithmetic shift (rounds toward -inf).
  - Clamp target_A to [A_MIN, 255]. Go to UPDATE.
- State UPDATE, one cycle:
  - If cfg_freeze = 0: atmospheric_light <= target_A, atmos_update = 1, atmos_locked <= 1.
  - If cfg_freeze = 1: no write and no pulse.
  - Go to IDLE, or to ACCUM if a start is pending (see next bullet).
- vs_rise while in CHECK, FILTER or UPDATE:
  - Set the start_pending flag.
  - The running sequence still completes.
  - On leaving UPDATE (or CHECK on reject), go to ACCUM with counters and dark_max cleared.
  - Pixels that arrived before then are not counted, so that frame will normally be rejected.
- Latency: atmospheric_light changes on the 3rd clock edge after the edge on which vs_fall is sampled. The chain is CHECK, FILTER, UPDATE, with the write on the UPDATE edge.
- Between updates, atmospheric_light is held constant. It is never below A_MIN after its first update.
- Arithmetic note: small positive diffs (< 2^ALPHA_SHIFT) yield no change. This steady-state offset is accepted.
- cfg_freeze is sampled only in UPDATE. Counting and checking continue while frozen, so frame_err stays meaningful.

Test Plan:
1. Reset, no frames: atmospheric_light=255, atmos_locked=0, no pulses for 1000 cycles.
2. H_DISP=4, V_DISP=2, ALPHA_SHIFT=2. Good frame with dark values {10,200,37,90,5,180,0,77} -> A=200 exactly 3 edges after vs_fall, atmos_update pulse of 1 cycle, atmos_locked=1.
3. After test 2, a good frame with max 100 -> diff=-100, A=200-25=175. Next good frame with max 255 -> diff=80, A=195.
4. Good frame with all-zero dark -> target 0 clamped: A=A_MIN=64 on first lock; with A=70 locked and ALPHA_SHIFT=0 -> A=64.
5. Frame of 7 pixels, or a frame with 3 href pulses -> frame_err 1-cycle pulse in CHECK, A unchanged, no atmos_update.
6. Edge cases:
   - cfg_freeze=1 over a good frame -> no update.
   - Reset asserted mid-ACCUM -> A=255; the vs_fall immediately after reset is ignored (no frame_err).
   - vs_rise one cycle after vs_fall -> the new frame misses pixels and raises frame_err at its end.
